fetch_unit: RTL

//  Instruction fetch stage directly downstream of the PC register block. It reads the current
//  PC, fetches the instruction word over a req/ack memory handshake and queues {instr, pc}

---
 rtl/fetch_unit.sv | 130 +++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: samples the PC, fetches over a req/ack memory handshake and
// queues {instr, pc} pairs for decode. It owns the PC write-enable.
module fetch_unit #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int BUF_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pcIn,
  output logic              pcWriteOut,
  input  logic              flush,
  output logic              memReq,
  output logic [ADDR_W-1:0] memAddr,
  input  logic              memAck,
  input  logic [DATA_W-1:0] memData,
  output logic              instValid,
  output logic [DATA_W-1:0] instOut,
  output logic [ADDR_W-1:0] instPc,
  input  logic              instReady,
  output logic              busy
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] addr_reg;
  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] instr_mem [BUF_DEPTH];
  logic [ADDR_W-1:0] pc_mem    [BUF_DEPTH];
  logic              launch;
  logic              push;
  logic              pop;

  // Pointers wrap explicitly so a non-power-of-two depth works.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    push      = 1'b0;
    case (state)
      IDLE: begin
        // Space is reserved at launch, so a later push can never overflow.
        if (!flush && (count < CNT_W'(BUF_DEPTH))) begin
          launch    = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (flush) begin
          state_nxt = memAck ? IDLE : DISCARD;
        end else if (memAck) begin
          push      = 1'b1;
          state_nxt = IDLE;
        end
      end
      DISCARD: begin
        if (memAck) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign pop        = instValid && instReady;
  assign pcWriteOut = flush || push;
  assign memReq     = (state != IDLE);
  assign busy       = (state != IDLE);
  assign memAddr    = addr_reg;
  assign instValid  = (count != '0);
  assign instOut    = instr_mem[rd_ptr];
  assign instPc     = pc_mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      addr_reg <= '0;
    end else begin
      state <= state_nxt;
      if (launch) addr_reg <= pcIn;
    end
  end

  // NOTE: the FIFO storage is reset because the head is visible on instOut/instPc even
  // when empty and must read as 0 after reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        instr_mem[wr_ptr] <= memData;
        pc_mem[wr_ptr]    <= addr_reg;
        wr_ptr            <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
